// File: rtl/sized_ram.sv
// sized_ram: single-port word RAM with byte/halfword/word load-store requests.
// Requests are accepted while READY and answered exactly one cycle later.
// After reset an optional sweep zeroes every word before traffic is allowed.
module sized_ram #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [AW-1:0]   cnt_r;
    logic [31:0]     mem_r [DEPTH];

    logic [31:0]     off_s;
    logic            in_range_s;
    logic [AW-1:0]   idx_s;
    logic            err_s;
    logic            accept_s;
    logic            store_s;
    logic [3:0]      mask_s;
    logic [31:0]     wdata_al_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     load_data_s;

    logic            rsp_valid_r;
    logic            rsp_err_r;
    logic [31:0]     rsp_rdata_r;

    // True when the size/alignment/range combination cannot be serviced.
    function automatic logic req_is_bad(input logic [1:0] size,
                                        input logic [1:0] lo,
                                        input logic       in_range);
        logic bad;
        case (size)
            2'b00:   bad = ~in_range;
            2'b01:   bad = lo[0] | ~in_range;
            2'b10:   bad = (lo != 2'b00) | ~in_range;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every candidate lane sees it.
    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pull the addressed lane(s) down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Request decode: offset from BASE, range check, lane selection, load data.
    always_comb begin
        off_s       = req_addr - BASE;
        in_range_s  = (req_addr >= BASE) && ({1'b0, off_s} < SPAN);
        idx_s       = off_s[AW+1:2];
        err_s       = req_is_bad(req_size, req_addr[1:0], in_range_s);
        accept_s    = req_valid & req_ready;
        store_s     = accept_s & req_write & ~err_s;
        mask_s      = lane_mask(req_size, req_addr[1:0]);
        wdata_al_s  = lane_data(req_size, req_wdata);
        rd_word_s   = mem_r[idx_s];
        if (accept_s && !err_s && !req_write) begin
            load_data_s = load_extract(req_size, req_unsigned, req_addr[1:0], rd_word_s);
        end else begin
            load_data_s = 32'd0;
        end
    end

    // State register: reset picks the sweep or goes straight to READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= INIT_CLEAR ? ST_CLEAR : ST_READY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: leave CLEAR once the last word has been zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_READY;
        endcase
    end

    // State outputs; reset forces the handshake closed regardless of state.
    always_comb begin
        if (rst) begin
            req_ready = 1'b0;
            busy      = INIT_CLEAR;
        end else begin
            req_ready = (state_r == ST_READY);
            busy      = (state_r == ST_CLEAR);
        end
    end

    // Sweep counter: restarts at 0 on reset, advances only while clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r == ST_CLEAR && cnt_r != LAST_IDX) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= '0;
        end
    end

    // Array writes: sweep zeroes one word per cycle, stores update selected lanes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_CLEAR) begin
                mem_r[cnt_r] <= 32'd0;
            end else if (store_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_s[b]) begin
                        mem_r[idx_s][8*b +: 8] <= wdata_al_s[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response registers: one pulse per accepted request, data zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s & err_s;
            rsp_rdata_r <= load_data_s;
        end
    end

    // Reset in the response cycle cancels the pending response.
    always_comb begin
        if (rst) begin
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            rsp_rdata = 32'd0;
        end else begin
            rsp_valid = rsp_valid_r;
            rsp_err   = rsp_err_r;
            rsp_rdata = rsp_rdata_r;
        end
    end

endmodule

// File: tb/tb_sized_ram.sv
// Directed bench for sized_ram (DEPTH=16, BASE=0, INIT_CLEAR=1).
module tb_sized_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sized_ram #(
        .DEPTH(16),
        .BASE(32'h0000_0000),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    // Present one request for one edge and return what appears after that edge.
    task automatic xfer(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic v, output logic [31:0] rd, output logic e);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        v  = rsp_valid;
        rd = rsp_rdata;
        e  = rsp_err;
    endtask

    task automatic test_reset;
        logic v; logic [31:0] rd; logic e; int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
        total++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b want=0/0", rsp_rdata, rsp_err); end
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep_start_busy got=%b want=1", busy); end
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (!busy) break;
        end
        total++; if (n != 16) begin bad++; $display("FAIL sweep_len got=%0d want=16", n); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_sweep got=%b want=1", req_ready); end
        xfer(1'b0, 2'b10, 1'b0, 32'h3C, 32'd0, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h0000_0000) begin bad++; $display("FAIL clear_load_3c got=%b/%b/%h want=1/0/00000000", v, e, rd); end
    endtask

    task automatic test_stores;
        logic v; logic [31:0] rd; logic e;
        xfer(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL store_rsp got=%b/%b/%h want=1/0/0", v, e, rd); end
        xfer(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAA, v, rd, e);
        xfer(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234_BEEF, v, rd, e);
        xfer(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, v, rd, e);
        total++; if (v !== 1'b1 || rd !== 32'hBEEF_AA44) begin bad++; $display("FAIL merged_word got=%b/%h want=1/beefaa44", v, rd); end
    endtask

    task automatic test_load_ext;
        logic v; logic [31:0] rd; logic e;
        xfer(1'b0, 2'b00, 1'b0, 32'h9, 32'd0, v, rd, e);
        total++; if (rd !== 32'hFFFF_FFAA) begin bad++; $display("FAIL lb_9 got=%h want=ffffffaa", rd); end
        xfer(1'b0, 2'b00, 1'b1, 32'h9, 32'd0, v, rd, e);
        total++; if (rd !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_9 got=%h want=000000aa", rd); end
        xfer(1'b0, 2'b01, 1'b0, 32'hA, 32'd0, v, rd, e);
        total++; if (rd !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_a got=%h want=ffffbeef", rd); end
        xfer(1'b0, 2'b01, 1'b1, 32'hA, 32'd0, v, rd, e);
        total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_a got=%h want=0000beef", rd); end
        xfer(1'b0, 2'b00, 1'b0, 32'h8, 32'd0, v, rd, e);
        total++; if (rd !== 32'h0000_0044) begin bad++; $display("FAIL lb_8 got=%h want=00000044", rd); end
        xfer(1'b0, 2'b00, 1'b0, 32'hB, 32'd0, v, rd, e);
        total++; if (rd !== 32'hFFFF_FFBE) begin bad++; $display("FAIL lb_b got=%h want=ffffffbe", rd); end
        xfer(1'b0, 2'b10, 1'b1, 32'h8, 32'd0, v, rd, e);
        total++; if (rd !== 32'hBEEF_AA44) begin bad++; $display("FAIL lw_uns got=%h want=beefaa44", rd); end
    endtask

    task automatic test_errors;
        logic v; logic [31:0] rd; logic e;
        xfer(1'b0, 2'b10, 1'b0, 32'h6, 32'd0, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_lw_6 got=%b/%b/%h want=1/1/0", v, e, rd); end
        xfer(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_1234, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_sh_5 got=%b/%b/%h want=1/1/0", v, e, rd); end
        xfer(1'b1, 2'b11, 1'b0, 32'h8, 32'd0, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_size3 got=%b/%b/%h want=1/1/0", v, e, rd); end
        xfer(1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFF_FFFF, v, rd, e);
        total++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL err_oor got=%b/%b/%h want=1/1/0", v, e, rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, v, rd, e);
        total++; if (e !== 1'b0 || rd !== 32'hBEEF_AA44) begin bad++; $display("FAIL err_keep_8 got=%b/%h want=0/beefaa44", e, rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h4, 32'd0, v, rd, e);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL err_keep_4 got=%h want=0", rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, v, rd, e);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL err_keep_0 got=%h want=0", rd); end
    endtask

    task automatic test_boundary;
        logic v; logic [31:0] rd; logic e;
        xfer(1'b1, 2'b00, 1'b0, 32'h3F, 32'h0000_005A, v, rd, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_3f_err got=%b want=0", e); end
        xfer(1'b0, 2'b10, 1'b0, 32'h3C, 32'd0, v, rd, e);
        total++; if (rd !== 32'h5A00_0000) begin bad++; $display("FAIL lw_3c got=%h want=5a000000", rd); end
        xfer(1'b0, 2'b01, 1'b0, 32'h3E, 32'd0, v, rd, e);
        total++; if (rd !== 32'h0000_5A00) begin bad++; $display("FAIL lh_3e got=%h want=00005a00", rd); end
        xfer(1'b0, 2'b00, 1'b0, 32'h40, 32'd0, v, rd, e);
        total++; if (e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lb_40 got=%b/%h want=1/0", e, rd); end
    endtask

    task automatic test_back_to_back;
        logic v1, v2; logic [31:0] rd1, rd2; logic e1, e2;
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, v1, rd1, e1);
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, v2, rd2, e2);
        total++; if (v1 !== 1'b1 || v2 !== 1'b1) begin bad++; $display("FAIL b2b_pulses got=%b%b want=11", v1, v2); end
        total++; if (rd2 !== 32'hCAFE_F00D || e2 !== 1'b0) begin bad++; $display("FAIL b2b_data got=%h/%b want=cafef00d/0", rd2, e2); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL idle_rsp got=%b/%h/%b want=0/0/0", rsp_valid, rsp_rdata, rsp_err); end
    endtask

    task automatic test_mid_sweep;
        logic v; logic [31:0] rd; logic e; int n;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_kills_rsp got=%b want=0", rsp_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("FAIL sweep_ignore%0d got=%b/%b want=0/0", i, rsp_valid, req_ready); end
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b/%b want=1/0", busy, req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (!busy) break;
        end
        total++; if (n != 16) begin bad++; $display("FAIL resweep_len got=%0d want=16", n); end
        xfer(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, v, rd, e);
        total++; if (v !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL resweep_8 got=%b/%h want=1/0", v, rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, v, rd, e);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL resweep_10 got=%h want=0", rd); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_load_ext();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
